// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue-side controller for a combinational ALU. It decodes an RV32
//   instruction when the instruction is captured into the ISSUE stage. It then
//   drives ALU control and operands from the ISSUE registers. The ALU result,
//   the branch resolution (BEQ/BNE) and the branch target are captured into the
//   RESULT stage, which is presented to writeback.
//   The two stages use a valid/ready handshake. A flush input kills every
//   in-flight instruction.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake
//   in_instr/in_rs1/in_rs2/in_pc  instruction word, register values, PC
//   flush                     drop ISSUE and RESULT contents
//   alu_ctr/alu_a/alu_b       to ALU (AND=0, OR=1, ADD=2, SUB=3)
//   alu_out/alu_zero          from ALU
//   wb_valid/wb_ready         downstream handshake
//   wb_we/wb_rd/wb_data       register write request
//   br_taken/br_target        branch resolution (qualified by wb_valid)
//   illegal                   unsupported instruction (qualified by wb_valid)
//
// Build option
//   ALU_ISSUE_BYPASS_EN : when defined, operands are forwarded from the
//   RESULT stage if it holds a pending write to the source register.

module alu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic [CTR_W-1:0] alu_ctr,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             alu_zero,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic             illegal
);

  localparam logic [CTR_W-1:0] CTR_AND = 2'd0;
  localparam logic [CTR_W-1:0] CTR_OR  = 2'd1;
  localparam logic [CTR_W-1:0] CTR_ADD = 2'd2;
  localparam logic [CTR_W-1:0] CTR_SUB = 2'd3;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;

  // instruction fields
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_b_s;

  assign opcode_s = in_instr[6:0];
  assign funct3_s = in_instr[14:12];
  assign funct7_s = in_instr[31:25];
  assign rd_s     = in_instr[11:7];
  assign imm_i_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_b_s  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};

  // source operand values, optionally forwarded from RESULT
  logic [XLEN-1:0] rs1_s;
  logic [XLEN-1:0] rs2_s;

`ifdef ALU_ISSUE_BYPASS_EN
  logic fwd1_s;
  logic fwd2_s;
  assign fwd1_s = wb_valid && wb_we && (wb_rd != 5'd0) && (wb_rd == in_instr[19:15]);
  assign fwd2_s = wb_valid && wb_we && (wb_rd != 5'd0) && (wb_rd == in_instr[24:20]);
  assign rs1_s  = fwd1_s ? wb_data : in_rs1;
  assign rs2_s  = fwd2_s ? wb_data : in_rs2;
`else
  // register index fields only matter when forwarding is built in
  logic unused_rs_idx_s;
  assign unused_rs_idx_s = ^in_instr[19:15];
  assign rs1_s = in_rs1;
  assign rs2_s = in_rs2;
`endif

  // decoded controls for the instruction being captured
  logic [CTR_W-1:0] dec_ctr_s;
  logic [XLEN-1:0]  dec_a_s;
  logic [XLEN-1:0]  dec_b_s;
  logic             dec_we_s;
  logic [1:0]       dec_br_s;
  logic             dec_ill_s;

  // Instruction decode; anything unrecognised becomes an illegal ADD 0+0.
  always_comb begin
    dec_ctr_s = CTR_ADD;
    dec_a_s   = '0;
    dec_b_s   = '0;
    dec_we_s  = 1'b0;
    dec_br_s  = BR_NONE;
    dec_ill_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        dec_a_s = rs1_s;
        dec_b_s = rs2_s;
        if (funct7_s == 7'b0000000) begin
          dec_we_s = 1'b1;
          case (funct3_s)
            3'b000:  dec_ctr_s = CTR_ADD;
            3'b111:  dec_ctr_s = CTR_AND;
            3'b110:  dec_ctr_s = CTR_OR;
            default: dec_ill_s = 1'b1;
          endcase
        end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) begin
          dec_we_s  = 1'b1;
          dec_ctr_s = CTR_SUB;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      OP_I: begin
        dec_a_s  = rs1_s;
        dec_b_s  = imm_i_s;
        dec_we_s = 1'b1;
        case (funct3_s)
          3'b000:  dec_ctr_s = CTR_ADD;
          3'b111:  dec_ctr_s = CTR_AND;
          3'b110:  dec_ctr_s = CTR_OR;
          default: dec_ill_s = 1'b1;
        endcase
      end
      OP_B: begin
        dec_a_s   = rs1_s;
        dec_b_s   = rs2_s;
        dec_ctr_s = CTR_SUB;
        case (funct3_s)
          3'b000:  dec_br_s  = BR_EQ;
          3'b001:  dec_br_s  = BR_NE;
          default: dec_ill_s = 1'b1;
        endcase
      end
      default: dec_ill_s = 1'b1;
    endcase
    // illegal encodings never write and present zero operands
    if (dec_ill_s) begin
      dec_ctr_s = CTR_ADD;
      dec_a_s   = '0;
      dec_b_s   = '0;
      dec_we_s  = 1'b0;
      dec_br_s  = BR_NONE;
    end else begin
      dec_we_s = dec_we_s && (rd_s != 5'd0);
    end
  end

  // ISSUE stage state beyond the ALU-facing registers
  logic            issue_valid_r;
  logic [4:0]      iss_rd_r;
  logic            iss_we_r;
  logic [1:0]      iss_br_r;
  logic [XLEN-1:0] iss_pc_r;
  logic [XLEN-1:0] iss_bimm_r;
  logic            iss_ill_r;

  logic res_adv_s;
  logic accept_s;
  logic br_taken_s;

  assign res_adv_s = !wb_valid || wb_ready;
  assign in_ready  = !flush && (!issue_valid_r || res_adv_s);
  assign accept_s  = in_valid && in_ready;

  // Branch resolution from the ALU zero flag of the instruction in ISSUE.
  always_comb begin
    br_taken_s = 1'b0;
    case (iss_br_r)
      BR_EQ:   br_taken_s = alu_zero;
      BR_NE:   br_taken_s = !alu_zero;
      default: br_taken_s = 1'b0;
    endcase
  end

  // ISSUE and RESULT stage registers; flush outranks every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_r <= 1'b0;
      alu_ctr       <= CTR_ADD;
      alu_a         <= '0;
      alu_b         <= '0;
      iss_rd_r      <= 5'd0;
      iss_we_r      <= 1'b0;
      iss_br_r      <= BR_NONE;
      iss_pc_r      <= '0;
      iss_bimm_r    <= '0;
      iss_ill_r     <= 1'b0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
      br_taken      <= 1'b0;
      br_target     <= '0;
      illegal       <= 1'b0;
    end else if (flush) begin
      issue_valid_r <= 1'b0;
      wb_valid      <= 1'b0;
    end else begin
      if (res_adv_s) begin
        wb_valid <= issue_valid_r;
        if (issue_valid_r) begin
          wb_we     <= iss_we_r;
          wb_rd     <= iss_rd_r;
          wb_data   <= alu_out;
          br_taken  <= br_taken_s;
          br_target <= iss_pc_r + iss_bimm_r;
          illegal   <= iss_ill_r;
        end
      end
      if (accept_s) begin
        issue_valid_r <= 1'b1;
        alu_ctr       <= dec_ctr_s;
        alu_a         <= dec_a_s;
        alu_b         <= dec_b_s;
        iss_rd_r      <= rd_s;
        iss_we_r      <= dec_we_s;
        iss_br_r      <= dec_br_s;
        iss_pc_r      <= in_pc;
        iss_bimm_r    <= imm_b_s;
        iss_ill_r     <= dec_ill_s;
      end else if (res_adv_s) begin
        issue_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_rs1 = 32'd0;
  logic [31:0] in_rs2 = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        flush = 1'b0;
  logic [1:0]  alu_ctr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;

  int total = 0;
  int bad = 0;
  logic rand_mode = 1'b0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        taken;
    logic [31:0] target;
    logic        is_br;
    logic        ill;
  } exp_t;

  exp_t q[$];

  alu_issue_ctrl #(.XLEN(32), .CTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .flush(flush),
    .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // combinational ALU seen by the block
  always_comb begin
    case (alu_ctr)
      2'd0:    alu_out = alu_a & alu_b;
      2'd1:    alu_out = alu_a | alu_b;
      2'd2:    alu_out = alu_a + alu_b;
      default: alu_out = alu_a - alu_b;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ISA-level reference: what writeback must report for one instruction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc);
    exp_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] immi;
    logic [31:0] immb;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    immi = {{20{ins[31]}}, ins[31:20]};
    immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    e.we = 1'b0; e.rd = ins[11:7]; e.data = 32'd0; e.taken = 1'b0;
    e.target = 32'd0; e.is_br = 1'b0; e.ill = 1'b0;
    if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b000) begin e.we = 1'b1; e.data = a + b; end
    else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b111) begin e.we = 1'b1; e.data = a & b; end
    else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b110) begin e.we = 1'b1; e.data = a | b; end
    else if (op == 7'b0110011 && f7 == 7'h20 && f3 == 3'b000) begin e.we = 1'b1; e.data = a - b; end
    else if (op == 7'b0010011 && f3 == 3'b000) begin e.we = 1'b1; e.data = a + immi; end
    else if (op == 7'b0010011 && f3 == 3'b111) begin e.we = 1'b1; e.data = a & immi; end
    else if (op == 7'b0010011 && f3 == 3'b110) begin e.we = 1'b1; e.data = a | immi; end
    else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      e.is_br  = 1'b1;
      e.data   = a - b;
      e.taken  = (f3 == 3'b000) ? (a == b) : (a != b);
      e.target = pc + immb;
    end
    else e.ill = 1'b1;
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // random instruction; sources x1..x15, destinations x16..x31 so that
  // forwarding never changes the architectural result
  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [4:0]  s1, s2, d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          k;
    r  = $urandom;
    s1 = 5'($urandom_range(1, 15));
    s2 = 5'($urandom_range(1, 15));
    d  = 5'($urandom_range(16, 31));
    case ($urandom_range(0, 2))
      0:       f3 = 3'b000;
      1:       f3 = 3'b111;
      default: f3 = 3'b110;
    endcase
    if ($urandom_range(0, 4) == 0) f3 = r[14:12];
    k = int'($urandom_range(0, 9));
    if (k <= 2) begin
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 4) == 0) f7 = r[31:25];
      return enc_r(f7, s2, s1, f3, d);
    end else if (k <= 5) begin
      return enc_i(r[31:20], s1, f3, d);
    end else if (k <= 8) begin
      f3 = ($urandom_range(0, 5) == 0) ? r[14:12] : {2'b00, r[0]};
      return {r[31:25], s2, s1, f3, r[11:7], 7'b1100011};
    end else begin
      case ($urandom_range(0, 3))
        0:       return {r[31:7], 7'b0000011};
        1:       return {r[31:7], 7'b0110111};
        2:       return {r[31:7], 7'b1101111};
        default: return {r[31:7], 7'b0000000};
      endcase
    end
  endfunction

  // present one instruction and wait (bounded) until it is taken
  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] ma, input logic [31:0] mb);
    int n;
    in_instr = ins; in_rs1 = a; in_rs2 = b; in_pc = pc; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready got=0 expected=1 at %0t", $time);
    end else begin
      q.push_back(model(ins, ma, mb, pc));
    end
    @(posedge clk); #1;
  endtask

  task automatic sendn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    send(ins, a, b, pc, a, b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // random backpressure while rand_mode is on
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_mode) wb_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: scoreboard pop on every writeback transfer, hold check while stalled
  initial begin
    exp_t        e;
    logic        stalled;
    logic [31:0] h_data, h_tgt;
    logic [7:0]  h_ctl;
    stalled = 1'b0;
    h_data = 32'd0; h_tgt = 32'd0; h_ctl = 8'd0;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 32'(wb_valid), 32'd1);
          check("hold_data", wb_data, h_data);
          check("hold_target", br_target, h_tgt);
          check("hold_ctl", 32'({wb_we, wb_rd, br_taken, illegal}), 32'(h_ctl));
        end
        if (wb_valid && wb_ready) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL wb_unexpected: got wb_rd=%0d wb_data=%h expected no transfer", wb_rd, wb_data);
          end else begin
            e = q.pop_front();
            check("wb_we", 32'(wb_we), 32'(e.we));
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_data", wb_data, e.data);
            check("br_taken", 32'(br_taken), 32'(e.taken));
            check("illegal", 32'(illegal), 32'(e.ill));
            if (e.is_br) check("br_target", br_target, e.target);
          end
        end
        stalled = wb_valid && !wb_ready;
        h_data = wb_data; h_tgt = br_target;
        h_ctl = {wb_we, wb_rd, br_taken, illegal};
      end
    end
  end

  initial begin
    logic [31:0] ins, a, b, pc;
    logic [31:0] byp;
    int          n;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_alu_ctr", 32'(alu_ctr), 32'd2);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_wb_out", {wb_data[31:7], wb_we, wb_rd, br_taken}, 32'd0);
    check("rst_br_target", br_target, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;

    // ADDI x5,x0,7: latency and ISSUE-stage ALU drive
    sendn(enc_i(12'd7, 5'd0, 3'b000, 5'd5), 32'd0, 32'd0, 32'h40);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_issue_wb_valid", 32'(wb_valid), 32'd0);
    check("issue_alu_ctr", 32'(alu_ctr), 32'd2);
    check("issue_alu_a", alu_a, 32'd0);
    check("issue_alu_b", alu_b, 32'd7);
    @(negedge clk);
    check("lat_result_wb_valid", 32'(wb_valid), 32'd1);
    @(posedge clk); #1;

    // directed ALU cases, branches and an illegal opcode, back to back
    sendn(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd9, 32'h44);
    sendn(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd4), 32'hF0F0F0F0, 32'h0FF00FF0, 32'h48);
    sendn(enc_b(13'h1FF8, 5'd7, 5'd6, 3'b000), 32'h1234, 32'h1234, 32'h100);
    sendn(enc_b(13'h1FF8, 5'd7, 5'd6, 3'b001), 32'h1234, 32'h1234, 32'h100);
    sendn({25'h0012345, 7'b0000011}, 32'h11, 32'h22, 32'h104);
    sendn(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd0), 32'h5, 32'h6, 32'h108);
    idle(5);

    // backpressure: three back to back, wb_ready low for two cycles
    wb_ready = 1'b0;
    sendn(enc_i(12'hFFF, 5'd1, 3'b000, 5'd20), 32'd10, 32'd0, 32'h200);
    sendn(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd21), 32'hA0, 32'h0B, 32'h204);
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd22);
    in_rs1 = 32'd100; in_rs2 = 32'd23; in_valid = 1'b1;
    @(negedge clk);
    check("stall_in_ready_1", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("stall_in_ready_2", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    sendn(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd22), 32'd100, 32'd23, 32'h208);
    idle(5);

    // flush with both stages full; flushed entries must never write back
    wb_ready = 1'b0;
    sendn(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd23), 32'd1, 32'd2, 32'h300);
    sendn(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd24), 32'd3, 32'd4, 32'h304);
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd25);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    q.delete();
    @(negedge clk);
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    idle(4);

    // ADDI x1,x0,3 then ADD x2,x1,x1 with stale register values
`ifdef ALU_ISSUE_BYPASS_EN
    byp = 32'd3;
`else
    byp = 32'd0;
`endif
    sendn(enc_i(12'd3, 5'd0, 3'b000, 5'd1), 32'd0, 32'd0, 32'h400);
    idle(1);
    send(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'd0, 32'd0, 32'h404, byp, byp);
    idle(5);

    // randomized traffic with random backpressure and input gaps
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ins = gen_instr();
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      pc = {$urandom_range(0, 65535), 2'b00};
      sendn(ins, a, b, pc);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    in_valid = 1'b0;
    rand_mode = 1'b0;
    @(posedge clk); #1;
    wb_ready = 1'b1;

    // drain the scoreboard
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sits between decode/register-read and writeback, and drives the ALU from the issuing side.
- Per instruction it generates ALU control and operands, and presents them to the combinational ALU.
- It captures the ALU result and zero flag, resolves BEQ/BNE, and hands a registered result to writeback.
- Two-stage valid/ready pipeline (ISSUE, RESULT) with flush.

Parameters:
- XLEN, 32, datapath width (matches the shared data type).
- CTR_W, 2, ALU control width; encoding AND=0, OR=1, ADD=2, SUB=3 (shared control encoding).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept an instruction this cycle
- in_instr  in  32  RV32 instruction word
- in_rs1  in  XLEN  rs1 value
- in_rs2  in  XLEN  rs2 value
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill all in-flight instructions
- alu_ctr  out  CTR_W  ALU operation select
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_out  in  XLEN  ALU result (combinational from alu_ctr/alu_a/alu_b)
- alu_zero  in  1  ALU result == 0
- wb_valid  out  1  result valid
- wb_ready  in  1  writeback accepts result
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  XLEN  write data
- br_taken  out  1  branch taken (qualified by wb_valid)
- br_target  out  XLEN  PC + B-immediate
- illegal  out  1  unsupported instruction (qualified by wb_valid)

Behaviour:
- Decode is performed at capture into ISSUE.
- R-type (opcode 0110011), funct7=0000000: funct3 000 -> ADD, 111 -> AND, 110 -> OR.
- R-type, funct7=0100000 with funct3 000 -> SUB.
- I-type (opcode 0010011): funct3 000 -> ADDI (ADD), 111 -> ANDI (AND), 110 -> ORI (OR). B operand = sign-extended imm[11:0].
- Branch (opcode 1100011): funct3 000 -> BEQ, 001 -> BNE. Both use SUB with A=rs1, B=rs2. wb_we=0.
- Anything else: illegal=1, wb_we=0, alu_ctr=ADD, operands 0.
- rd=x0: wb_we forced 0.
- ISSUE register holds valid bit, ctr, A, B, rd, we, branch kind, pc, B-imm, illegal. alu_ctr/alu_a/alu_b are driven straight from ISSUE registers.
- RESULT register captures alu_out, alu_zero-derived br_taken, br_target = pc + sign-extended B-imm (mod 2^XLEN), rd, we, illegal.
- br_taken: BEQ = alu_zero, BNE = !alu_zero, else 0.
- Handshake: RESULT advances when !wb_valid || wb_ready.
- ISSUE advances into RESULT under the same condition.
- in_ready = !issue_valid || RESULT advances. Transfer occurs on in_valid && in_ready.
- Latency: instruction accepted at cycle N appears on wb_* at N+2 when unstalled. Throughput is 1 per cycle.
- Stall: with wb_valid && !wb_ready, all wb_* and ISSUE contents hold stable and in_ready=0 if ISSUE is full.
- Flush: clears issue_valid and wb_valid next edge. An input presented with flush is not accepted (in_ready=0 during flush). Flush has priority over all advances.
- Reset: issue_valid=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, br_taken=0, br_target=0, illegal=0, alu_ctr=ADD, alu_a=0, alu_b=0. in_ready=1 after reset deasserts.
- Reset mid-stall behaves as flush plus register clear.

Optional Feature:
- Macro ALU_ISSUE_BYPASS_EN.
- When defined: at capture, if RESULT holds a valid entry with wb_we=1 and wb_rd equals instr rs1 (or rs2), and that rd is nonzero, wb_data replaces in_rs1 (or in_rs2). The replacement also applies to branch operands.
- When undefined: operands are taken only from in_rs1/in_rs2; the upstream provider handles hazards.

Test Plan:
- Reset, then ADDI x5,x0,7 with wb_ready=1 -> wb_valid 2 cycles later, wb_rd=5, wb_data=7, wb_we=1, alu_ctr=ADD during ISSUE.
- SUB x3,x1,x2 with rs1=5, rs2=9 -> wb_data=0xFFFFFFFC. Then AND with 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
- BEQ at pc=0x100, imm=-8, rs1=rs2=0x1234 -> br_taken=1, br_target=0xF8, wb_we=0. BNE with the same operands -> br_taken=0.
- Back-to-back 3 instructions with wb_ready low 2 cycles -> wb_* stable while stalled, in_ready=0 after ISSUE fills, no loss/duplication; order preserved when wb_ready is released.
- Flush asserted with both stages full -> wb_valid=0 and in_ready=1 next cycle, no writeback of flushed entries. Opcode 0000011 -> illegal=1, wb_we=0.
- With ALU_ISSUE_BYPASS_EN: ADDI x1,x0,3 followed by ADD x2,x1,x1 with stale in_rs1=in_rs2=0 -> wb_data=6. Without the macro -> wb_data=0.
